mcycle_md: RTL and testbench
============================

# mcycle_md

Parametrised multi-cycle multiply/divide unit for the ARM datapath. It supports signed and unsigned multiplication and division at any operand width and returns a full double-width product or a quotient/remainder pair. It reports divide-by-zero and uses a Start/Busy/Done handshake. The datapath holds PC (WE_PC low) while Busy is high and writes results back on the Done cycle.

## Interface
- WIDTH, 32: operand and result width in bits; must be at least 4.
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only in IDLE.
- MCycleOp  in  2  operation select:
  - 00: signed multiply
  - 01: unsigned multiply
  - 10: signed divide
  - 11: unsigned divide
- Operand1  in  WIDTH  multiplicand or dividend.
- Operand2  in  WIDTH  multiplier or divisor.
- Result1  out  WIDTH  low half of the product, or the quotient.
- Result2  out  WIDTH  high half of the product, or the remainder.
- Busy  out  1  high while an operation is in flight.
- Done  out  1  one-cycle pulse; results are valid from this cycle.
- DivByZero  out  1  valid with Done; set for a divide with Operand2 == 0.

## Operation
- States and transitions:
  - IDLE -> RUN on Start.
  - RUN -> FINISH after the last iteration.
  - FINISH -> IDLE.
- Acceptance: Start=1 in IDLE, with RESET=0, at edge E0.
  - Operand1, Operand2 and MCycleOp are latched at E0.
  - Later input changes do not affect the operation.
- Signed operations:
  - Operands are converted to magnitudes at E0.
  - The result sign is recorded at E0.
  - Sign correction is applied in FINISH.
- Multiply:
  - Shift-add, one multiplier bit per RUN cycle, LSB first.
  - Accumulator is 2*WIDTH bits.
  - {Result2,Result1} is the exact 2*WIDTH-bit product, two's complement for signed.
- Divide:
  - Restoring division, one quotient bit per RUN cycle, MSB first.
  - Signed quotient truncates toward zero.
  - Signed remainder takes the sign of the dividend.
- Divide boundary cases:
  - Divisor 0: Result1 = all ones, Result2 = Operand1, DivByZero=1. Full latency still applies.
  - Signed -2^(WIDTH-1) / -1: Result1 = -2^(WIDTH-1) (wraps), Result2 = 0, DivByZero=0.
- DivByZero is 0 for multiplies.
- Results and DivByZero are held until the next Done.
- Start while Busy=1 is ignored. It is neither queued nor allowed to corrupt the operation.
- MCycleOp, Operand1 and Operand2 are don't-care outside the acceptance cycle.

## Timing
- Reset state: IDLE, Busy=0, Done=0, DivByZero=0, Result1=0, Result2=0. This applies at any edge with RESET=1, including mid-operation: the operation in flight is discarded and Done is not raised.
- Busy goes high after E0 and stays high through all RUN cycles plus the FINISH cycle.
  - Without early termination, RUN lasts exactly WIDTH cycles.
- At the edge leaving FINISH (E0+WIDTH+1 by default):
  - Result1, Result2 and DivByZero are registered.
  - Busy falls and Done=1 for exactly one cycle.
- Latency from acceptance to Done is WIDTH+1 edges. For WIDTH=32, Done is visible after edge E0+33.
- Back-to-back operation: Start may be accepted in the Done cycle, because state is IDLE. Busy is then high on the next cycle, so there are no idle gaps.
- RESET and Start asserted together: RESET wins and no operation is accepted.

## Configuration
- MCYCLE_EARLY_TERM_EN defined:
  - Multiply RUN ends after the first cycle in which the remaining unprocessed multiplier magnitude bits are all zero.
  - RUN always lasts at least 1 cycle.
  - Multiply latency is (index of highest set bit of |Operand2| + 1) + 1 edges. A multiplier of 0 gives 2 edges.
  - Divide latency is unchanged.
- MCYCLE_EARLY_TERM_EN undefined: every operation takes exactly WIDTH RUN cycles.
- Results are identical in both builds.

## Test plan
All scenarios use WIDTH=32.

- Signed multiply: MCycleOp=00, Operand1=0xFFFFFFFD (-3), Operand2=7 -> Result1=0xFFFFFFEB, Result2=0xFFFFFFFF, Done after E0+33 in the default build.
- Unsigned multiply: MCycleOp=01, 0xFFFFFFFF*0xFFFFFFFF -> Result1=0x00000001, Result2=0xFFFFFFFE, DivByZero=0.
- Signed divide: MCycleOp=10, Operand1=0xFFFFFFF9 (-7), Operand2=2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF. Repeat with 0x80000000 / 0xFFFFFFFF -> Result1=0x80000000, Result2=0.
- Divide by zero: MCycleOp=11, Operand1=100, Operand2=0 -> Result1=0xFFFFFFFF, Result2=100, DivByZero=1 with Done, Busy high for 33 cycles.
- Handshake and reset:
  - Pulse Start with new operands at E0+5: ignored, and the original result is unchanged.
  - Assert RESET at E0+10 of a new operation: next cycle Busy=0, Done never pulses, results are 0.
  - A following operation completes correctly.
  - A Start accepted in the Done cycle gives Busy=1 on the next cycle.
- Early termination:
  - With MCYCLE_EARLY_TERM_EN, unsigned 5*3 -> Result1=15, Done after E0+3.
  - With MCYCLE_EARLY_TERM_EN, Operand2=0 -> Done after E0+2, product 0.
  - Without the macro, 5*3 -> Done after E0+33.

Source files
------------

// File: rtl/mcycle_md.sv
// Multi-cycle shift-add multiplier / restoring divider with a Start/Busy/Done handshake.
// Optional build macro MCYCLE_EARLY_TERM_EN ends a multiply once no multiplier bits remain.
module mcycle_md #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_q, dbz_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] aux_q, aux_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   r1_q, r1_d;
  logic [WIDTH-1:0]   r2_q, r2_d;
  logic               dbz_out_q, dbz_out_d;
  logic               done_q, done_d;

  // Operand magnitudes and signs, only meaningful in the acceptance cycle.
  logic             op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign op_signed = ~MCycleOp[0];
  assign a_neg     = op_signed & Operand1[WIDTH-1];
  assign b_neg     = op_signed & Operand2[WIDTH-1];
  assign a_mag     = a_neg ? -Operand1 : Operand1;
  assign b_mag     = b_neg ? -Operand2 : Operand2;

  // Restoring-division step: acc holds {remainder, dividend/quotient}, aux[W-1:0] the divisor.
  logic [WIDTH:0]   div_s;
  logic             div_ge;
  logic [WIDTH-1:0] rem_new;

  assign div_s   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge  = div_s >= {1'b0, aux_q[WIDTH-1:0]};
  assign rem_new = div_ge ? (div_s[WIDTH-1:0] - aux_q[WIDTH-1:0]) : div_s[WIDTH-1:0];

  logic last_iter;
`ifdef MCYCLE_EARLY_TERM_EN
  assign last_iter = (count_q == CW'(WIDTH - 1)) ||
                     (!is_div_q && (mplier_q[WIDTH-1:1] == '0));
`else
  assign last_iter = (count_q == CW'(WIDTH - 1));
`endif

  // Sign-corrected results presented to the output registers in FINISH.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = dbz_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    state_d   = state_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    acc_d     = acc_q;
    aux_d     = aux_q;
    mplier_d  = mplier_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    dbz_out_d = dbz_out_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d   = S_RUN;
          count_d   = '0;
          is_div_d  = MCycleOp[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dbz_d     = MCycleOp[1] && (Operand2 == '0);
          if (MCycleOp[1]) begin
            acc_d    = {{WIDTH{1'b0}}, a_mag};
            aux_d    = {{WIDTH{1'b0}}, b_mag};
            mplier_d = '0;
          end else begin
            acc_d    = '0;
            aux_d    = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
          end
        end
      end

      S_RUN: begin
        count_d = count_q + 1'b1;
        if (is_div_q) begin
          acc_d = {rem_new, acc_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d    = acc_q + (mplier_q[0] ? aux_q : '0);
          aux_d    = aux_q << 1;
          mplier_d = mplier_q >> 1;
        end
        if (last_iter) state_d = S_FINISH;
      end

      S_FINISH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          r1_d      = quo_fix;
          r2_d      = rem_fix;
          dbz_out_d = dbz_q;
        end else begin
          r1_d      = prod_fix[WIDTH-1:0];
          r2_d      = prod_fix[2*WIDTH-1:WIDTH];
          dbz_out_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use <= so every register samples the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      acc_q     <= '0;
      aux_q     <= '0;
      mplier_q  <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      dbz_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      acc_q     <= acc_d;
      aux_q     <= aux_d;
      mplier_q  <= mplier_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      dbz_out_q <= dbz_out_d;
      done_q    <= done_d;
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Done      = done_q;
  assign Result1   = r1_q;
  assign Result2   = r2_q;
  assign DivByZero = dbz_out_q;

endmodule

// File: tb/tb_mcycle_md.sv
// Directed self-checking bench for mcycle_md (WIDTH=32): vector table plus handshake/reset sequences.
module tb_mcycle_md;
  localparam int W = 32;
`ifdef MCYCLE_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] opa, opb;
  logic [W-1:0] res1, res2;
  logic         busy, done, dbz;

  int checks   = 0;
  int failures = 0;

  mcycle_md #(.WIDTH(W)) dut (
    .CLK      (clk),
    .RESET    (rst),
    .Start    (start),
    .MCycleOp (op),
    .Operand1 (opa),
    .Operand2 (opb),
    .Result1  (res1),
    .Result2  (res2),
    .Busy     (busy),
    .Done     (done),
    .DivByZero(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    logic         dbz;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Edges from acceptance to the visible Done pulse.
  function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] b);
    logic [W-1:0] m;
    int           n;
    m = (!o[0] && b[W-1]) ? -b : b;
    n = 0;
    for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    if (n == 0) n = 1;
    return (EARLY && !o[1]) ? n + 1 : W + 1;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
  endtask

  // Takes the acceptance edge, scrambles inputs, and counts edges until Done.
  // inject_at >= 1 pulses a competing Start sampled at edge E0+inject_at.
  task automatic wait_done(input int inject_at, output int lat, output int busy_n,
                           output logic first_busy);
    int k;
    @(posedge clk); #1;
    start = 1'b0;
    op    = 2'($urandom);
    opa   = $urandom;
    opb   = $urandom;
    first_busy = busy;
    k = 0; lat = -1; busy_n = 0;
    while (lat < 0 && k <= 100) begin
      if (busy) busy_n++;
      if (k == inject_at - 1) begin
        start = 1'b1; op = 2'b01; opa = 32'd5; opb = 32'd3;
      end else if (k == inject_at) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
      if (done) lat = k;
    end
    start = 1'b0;
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no Done within %0d edges expected Done", k);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v, input int inject_at);
    int   lat, busy_n, el;
    logic fb;
    el = exp_lat(v.op, v.b);
    issue(v.op, v.a, v.b);
    wait_done(inject_at, lat, busy_n, fb);
    check({tag, "_r1"}, 64'(res1), 64'(v.r1));
    check({tag, "_r2"}, 64'(res2), 64'(v.r2));
    check({tag, "_dbz"}, 64'(dbz), 64'(v.dbz));
    check({tag, "_lat"}, 64'(lat), 64'(el));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(el));
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    check({tag, "_idle_after"}, 64'(busy), 64'd0);
    check({tag, "_r1_held"}, 64'(res1), 64'(v.r1));
  endtask

  initial begin
    int   lat, busy_n, done_seen;
    logic fb;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};
    vecs[4]  = '{2'b11, 32'd100,       32'd0,         32'hFFFF_FFFF, 32'd100,       1'b1};
    vecs[5]  = '{2'b01, 32'd5,         32'd3,         32'd15,        32'd0,         1'b0};
    vecs[6]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b0};
    vecs[7]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0};
    vecs[8]  = '{2'b11, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    vecs[9]  = '{2'b10, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1};
    vecs[10] = '{2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[11] = '{2'b01, 32'd0,         32'h0001_2345, 32'd0,         32'd0,         1'b0};
    vecs[12] = '{2'b01, 32'd5,         32'd0,         32'd0,         32'd0,         1'b0};

    // Reset state, with Start held during the final reset edge.
    rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    #1;
    issue(2'b01, 32'd5, 32'd3);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(dbz), 64'd0);
    check("rst_r1", 64'(res1), 64'd0);
    check("rst_r2", 64'(res2), 64'd0);
    @(posedge clk); #1;
    check("rst_start_not_accepted", 64'(busy), 64'd0);

    for (int i = 0; i < 13; i++) run_vec($sformatf("v%0d", i), vecs[i], -1);

    // Start pulsed at E0+5 while busy must be ignored and not queued.
    run_vec("ignored_start", vecs[8], 5);

    // Reset at E0+10 discards the operation and clears the results.
    issue(vecs[0].op, vecs[0].a, vecs[0].b);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_r1", 64'(res1), 64'd0);
    check("midrst_r2", 64'(res2), 64'd0);
    check("midrst_dbz", 64'(dbz), 64'd0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) done_seen++;
      @(posedge clk); #1;
    end
    check("midrst_no_done", 64'(done_seen), 64'd0);
    run_vec("after_rst", vecs[2], -1);

    // Back-to-back: a Start issued in the Done cycle is accepted immediately.
    issue(vecs[5].op, vecs[5].a, vecs[5].b);
    wait_done(-1, lat, busy_n, fb);
    check("b2b_first_r1", 64'(res1), 64'(vecs[5].r1));
    check("b2b_first_done", 64'(done), 64'd1);
    issue(vecs[7].op, vecs[7].a, vecs[7].b);
    wait_done(-1, lat, busy_n, fb);
    check("b2b_busy_next", 64'(fb), 64'd1);
    check("b2b_second_r1", 64'(res1), 64'(vecs[7].r1));
    check("b2b_second_r2", 64'(res2), 64'(vecs[7].r2));
    check("b2b_second_lat", 64'(lat), 64'(exp_lat(vecs[7].op, vecs[7].b)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
